// File: rtl/alu_op_encoder.sv
// alu_op_encoder: debounces five push-buttons into a registered, priority-encoded ALU op code
module alu_op_encoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic [2:0] ALUControl,
  output logic       op_valid,
  output logic [4:0] btn_state
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic [4:0] raw, s1, s2, stable, stable_d, press, pick;
  logic [W-1:0] cnt [5];
  logic [2:0] code;
  assign raw = {btnC, btnR, btnL, btnD, btnU};
  assign press = stable & ~stable_d;
  assign pick = STICKY ? press : stable;
  assign btn_state = stable;
  // bit 0 (btnU) wins; codes are bit index + 1
  always_comb code = pick[0] ? 3'd1 : pick[1] ? 3'd2 : pick[2] ? 3'd3 : pick[3] ? 3'd4 : pick[4] ? 3'd5 : 3'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      stable_d <= '0;
      ALUControl <= '0;
      op_valid <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable_d <= stable;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
      op_valid <= STICKY ? |press : code != ALUControl;
      if (!STICKY || |press) ALUControl <= code;
    end
  end
endmodule

// File: tb/tb_alu_op_encoder.sv
// tb_alu_op_encoder: directed scenarios plus randomized run against a history-based model
module tb_alu_op_encoder;
  localparam int D = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [2:0] alu_s, alu_m;
  logic v_s, v_m;
  logic [4:0] st_s, st_m;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_op_encoder #(.DEBOUNCE_CYCLES(D), .STICKY(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .btnU(btn[0]), .btnD(btn[1]), .btnL(btn[2]), .btnR(btn[3]), .btnC(btn[4]),
    .ALUControl(alu_s), .op_valid(v_s), .btn_state(st_s));
  alu_op_encoder #(.DEBOUNCE_CYCLES(D), .STICKY(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .btnU(btn[0]), .btnD(btn[1]), .btnL(btn[2]), .btnR(btn[3]), .btnC(btn[4]),
    .ALUControl(alu_m), .op_valid(v_m), .btn_state(st_m));

  // model: raw seen two edges late; a level is accepted once the last D synced samples all disagree with it
  logic [4:0] r1 = '0, r2 = '0, ms = '0, mp = '0;
  logic [4:0] hist[$];
  logic [2:0] ea_s = '0, ea_m = '0;
  logic ev_s = 1'b0, ev_m = 1'b0;

  function automatic logic [2:0] enc(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic cyc();
    logic [4:0] pr;
    logic [2:0] n;
    bit all;
    @(posedge clk);
    if (!rst_n) begin
      r1 = '0; r2 = '0; ms = '0; mp = '0; hist.delete();
      ea_s = '0; ea_m = '0; ev_s = 1'b0; ev_m = 1'b0;
    end else begin
      pr = ms & ~mp;
      ev_s = |pr;
      if (ev_s) ea_s = enc(pr);
      n = enc(ms);
      ev_m = n != ea_m;
      ea_m = n;
      mp = ms;
      hist.push_back(r2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D)
        for (int i = 0; i < 5; i++) begin
          all = 1;
          foreach (hist[j]) if (hist[j][i] == ms[i]) all = 0;
          if (all) ms[i] = ~ms[i];
        end
      r2 = r1;
      r1 = btn;
    end
    #1;
  endtask

  task automatic settle();
    repeat (D + 6) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if ({alu_s, v_s, st_s, alu_m, v_m, st_m} !== '0) begin
        fails++;
        $display("FAIL reset cyc %0d: s=%h/%b/%b m=%h/%b/%b, want all zero", k, alu_s, v_s, st_s, alu_m, v_m, st_m);
      end
    end
    btn = '0;
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_clean_press();
    btn[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      tests++;
      if (st_s[2] !== (k >= 10)) begin
        fails++;
        $display("FAIL clean_state k=%0d: got %b want %b", k, st_s[2], k >= 10);
      end
      tests++;
      if (v_s !== (k == 11) || alu_s !== (k >= 11 ? 3'd3 : 3'd0)) begin
        fails++;
        $display("FAIL clean_op k=%0d: alu=%0d v=%b want alu=%0d v=%b", k, alu_s, v_s, k >= 11 ? 3 : 0, k == 11);
      end
    end
    btn[2] = 1'b0;
    for (int k = 0; k < D + 6; k++) begin
      cyc();
      tests++;
      if (alu_s !== 3'd3 || v_s !== 1'b0) begin
        fails++;
        $display("FAIL clean_release k=%0d: alu=%0d v=%b want alu=3 v=0", k, alu_s, v_s);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    for (int k = 0; k < 30; k++) begin
      btn[3] = ((k / 3) % 2) == 0;
      cyc();
      tests++;
      if (st_s[3] !== 1'b0 || v_s !== 1'b0 || alu_s !== 3'd3) begin
        fails++;
        $display("FAIL bounce k=%0d: state=%b v=%b alu=%0d want 0/0/3", k, st_s[3], v_s, alu_s);
      end
    end
    btn[3] = 1'b1;
    pulses = 0;
    for (int k = 0; k < D + 8; k++) begin
      cyc();
      pulses += v_s;
    end
    tests++;
    if (pulses != 1 || alu_s !== 3'd4) begin
      fails++;
      $display("FAIL bounce_accept: pulses=%0d alu=%0d want 1 and 4", pulses, alu_s);
    end
    btn[3] = 1'b0;
    settle();
  endtask

  task automatic test_simultaneous();
    int pulses;
    btn[1] = 1'b1;
    btn[4] = 1'b1;
    pulses = 0;
    for (int k = 0; k < D + 6; k++) begin
      cyc();
      pulses += v_s;
    end
    tests++;
    if (pulses != 1 || alu_s !== 3'd2) begin
      fails++;
      $display("FAIL simul_press: pulses=%0d alu=%0d want 1 and 2", pulses, alu_s);
    end
    btn[4] = 1'b0;
    pulses = 0;
    for (int k = 0; k < D + 6; k++) begin
      cyc();
      pulses += v_s;
    end
    tests++;
    if (pulses != 0 || alu_s !== 3'd2) begin
      fails++;
      $display("FAIL simul_release: pulses=%0d alu=%0d want 0 and 2", pulses, alu_s);
    end
    btn[4] = 1'b1;
    pulses = 0;
    for (int k = 0; k < D + 6; k++) begin
      cyc();
      pulses += v_s;
    end
    tests++;
    if (pulses != 1 || alu_s !== 3'd5) begin
      fails++;
      $display("FAIL simul_repress: pulses=%0d alu=%0d want 1 and 5", pulses, alu_s);
    end
    btn = '0;
    settle();
  endtask

  task automatic test_momentary();
    btn[0] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      cyc();
      if (k == 20) btn[0] = 1'b0;
      tests++;
      if (v_m !== (k == 11 || k == 31) || alu_m !== ((k >= 11 && k < 31) ? 3'd1 : 3'd0)) begin
        fails++;
        $display("FAIL momentary k=%0d: alu=%0d v=%b want alu=%0d v=%b", k, alu_m, v_m,
                 (k >= 11 && k < 31) ? 1 : 0, k == 11 || k == 31);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn[4] = 1'b1;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    tests++;
    if (alu_s !== 3'd0 || v_s !== 1'b0 || st_s !== 5'd0) begin
      fails++;
      $display("FAIL midreset_clear: alu=%0d v=%b st=%b want zeros", alu_s, v_s, st_s);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      tests++;
      if (alu_s !== (k >= 11 ? 3'd5 : 3'd0) || v_s !== (k == 11)) begin
        fails++;
        $display("FAIL midreset k=%0d: alu=%0d v=%b want alu=%0d v=%b", k, alu_s, v_s, k >= 11 ? 5 : 0, k == 11);
      end
    end
    btn = '0;
    settle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(5) == 0) btn[$urandom_range(4)] ^= 1'b1;
      rst_n = $urandom_range(299) != 0;
      cyc();
      tests++;
      if (alu_s !== ea_s || v_s !== ev_s || st_s !== ms) begin
        fails++;
        $display("FAIL random_sticky k=%0d: got %0d/%b/%b want %0d/%b/%b", k, alu_s, v_s, st_s, ea_s, ev_s, ms);
      end
      tests++;
      if (alu_m !== ea_m || v_m !== ev_m || st_m !== ms) begin
        fails++;
        $display("FAIL random_moment k=%0d: got %0d/%b/%b want %0d/%b/%b", k, alu_m, v_m, st_m, ea_m, ev_m, ms);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_momentary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
Front-end that converts the five raw, bouncing push-buttons into a clean, registered 3-bit ALU operation code for the ALU's ALUControl input.
- Synchronises and debounces each button, detects accepted presses, priority-encodes them and holds the resulting op code.
- Emits a one-cycle strobe whenever a new op is accepted.
- Replaces the combinational button-to-ALUControl mux at the board top level.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive clk cycles a synchronised level must persist before acceptance (1 ms @ 100 MHz); legal range >= 1.
STICKY, 1, 1 = op code latched on press and held after release; 0 = op code follows currently held buttons.

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
btnU  input  1  raw button, op 001
btnD  input  1  raw button, op 010
btnL  input  1  raw button, op 011
btnR  input  1  raw button, op 100
btnC  input  1  raw button, op 101
ALUControl  output  3  registered op code to ALU
op_valid  output  1  one-cycle strobe, coincident with each accepted op update
btn_state  output  5  debounced levels {btnC,btnR,btnL,btnD,btnU}

Behaviour:
- Reset: rst_n sampled low on a clk edge clears everything: sync flops, stable levels, debounce counters, ALUControl=000, op_valid=0, btn_state=00000. Reset mid-debounce discards partial counts.
- Synchroniser: per button, 2-flop chain; output is sync level.
- Debounce, per button, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == stable -> counter = 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1 -> counter + 1.
  - sync != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= sync, counter = 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- btn_state = stable levels.
- Press event: stable 0->1 transition for that button, a one-cycle internal pulse.
- Priority for simultaneous events or levels: U > D > L > R > C.
- STICKY=1:
  - On any press event, ALUControl <= code of highest-priority pressing button and op_valid = 1 the same cycle.
  - Re-pressing the current op still pulses op_valid.
  - Releases change nothing.
  - ALUControl returns to 000 only on reset.
- STICKY=0:
  - ALUControl <= priority encode of stable levels (000 if none).
  - op_valid = 1 in the cycle ALUControl takes a value different from its previous one, including return to 000.
- Latency: raw edge held steady from cycle 0 gives sync at cycle 2, stable at cycle 2+DEBOUNCE_CYCLES, and ALUControl/op_valid at cycle 3+DEBOUNCE_CYCLES.
- Other rules:
  - op_valid is never high two consecutive cycles unless a new press event occurs in each cycle.
  - Outputs are purely registered, with no combinational path from btn* to outputs.
  - Buttons are independent; bounces on one never affect another's counter.

Test Plan:
1. Reset: DEBOUNCE_CYCLES=8, STICKY=1, rst_n=0 for 3 cycles with btnU=1 -> ALUControl=000, op_valid=0, btn_state=00000 throughout reset.
2. Clean press: btnL 0->1 held at cycle 0 -> btn_state[2]=1 at cycle 10; ALUControl=011 and op_valid=1 at cycle 11 only. Release afterwards -> ALUControl stays 011, no op_valid.
3. Bounce rejection: btnR toggles every 3 cycles for 30 cycles, then holds 1 -> no change until 8 stable cycles; then exactly one op_valid, with ALUControl=100.
4. Simultaneous: btnD and btnC rise in the same cycle -> single op_valid, ALUControl=010. Later btnC released and re-pressed (D still held) -> ALUControl=101, op_valid pulse.
5. Momentary mode: STICKY=0, press btnU, hold 20 cycles, release -> ALUControl 000->001->000, one op_valid on each change, 11-cycle latency each way.
6. Reset mid-debounce: btnC high 5 cycles, then rst_n=0 for 1 cycle with btnC still high -> count restarts; ALUControl=101 appears 11 cycles after rst_n returns high.
